// File: rtl/instr_loader_pkg.sv
// Shared types and sizing for the program-load / run sequencer.
// Imported by instr_loader.
package instr_loader_pkg;

   localparam int INSTR_W    = 9;
   localparam int PROG_DEPTH = 128;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/instr_loader.sv
// Loads a host program into instruction memory, then runs the core until done.
// Optional core run-cycle counter: define INSTR_LOADER_CYCLE_CNT_EN.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int D     = 12,
   parameter int W     = INSTR_W,
   parameter int DEPTH = PROG_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_last,
   output logic          imem_we,
   output logic [D-1:0]  imem_addr,
   output logic [W-1:0]  imem_wdata,
   output logic          core_reset,
   input  logic          core_done,
   output logic          done,
   output logic          overflow
`ifdef INSTR_LOADER_CYCLE_CNT_EN
   ,output logic [31:0]  cycle_cnt
`endif
);

   localparam logic [D-1:0] LAST_IDX = D'(DEPTH - 1);

   state_t         r_state;
   logic [D-1:0]   r_cnt;
   logic           r_in_ready;
   logic           r_imem_we;
   logic [D-1:0]   r_imem_addr;
   logic [W-1:0]   r_imem_wdata;
   logic           r_core_reset;
   logic           r_done;
   logic           r_overflow;

   logic           w_accept;
   logic           w_final_beat;

   assign w_accept     = in_valid && r_in_ready;
   assign w_final_beat = in_last || (r_cnt == LAST_IDX);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_in_ready   <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_core_reset <= 1'b1;
         r_done       <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_state    <= ST_LOAD;
                  r_in_ready <= 1'b1;
                  r_cnt      <= '0;
                  r_overflow <= 1'b0;
               end
            end

            ST_LOAD: begin
               if (!req) begin
                  r_state      <= ST_IDLE;
                  r_in_ready   <= 1'b0;
                  r_imem_we    <= 1'b0;
                  r_core_reset <= 1'b1;
               end else begin
                  r_imem_we <= 1'b0;
                  if (w_accept) begin
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_cnt;
                     r_imem_wdata <= in_data;
                     // Counter saturates at the last slot so it can never wrap.
                     if (r_cnt != LAST_IDX) begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                     if (w_final_beat) begin
                        r_state    <= ST_FLUSH;
                        r_in_ready <= 1'b0;
                        r_overflow <= ~in_last;
                     end
                  end
               end
            end

            ST_FLUSH: begin
               r_imem_we <= 1'b0;
               if (!req) begin
                  r_state      <= ST_IDLE;
                  r_core_reset <= 1'b1;
               end else begin
                  r_state      <= ST_RUN;
                  r_core_reset <= 1'b0;
               end
            end

            ST_RUN: begin
               if (!req) begin
                  r_state      <= ST_IDLE;
                  r_core_reset <= 1'b1;
               end else if (core_done) begin
                  r_state      <= ST_DONE;
                  r_core_reset <= 1'b1;
                  r_done       <= 1'b1;
               end
            end

            ST_DONE: begin
               if (!req) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b0;
               end
            end

            default: begin
               r_state      <= ST_IDLE;
               r_in_ready   <= 1'b0;
               r_imem_we    <= 1'b0;
               r_core_reset <= 1'b1;
               r_done       <= 1'b0;
            end
         endcase
      end
   end

`ifdef INSTR_LOADER_CYCLE_CNT_EN
   logic [31:0] r_cycle_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle_cnt <= '0;
      end else if (r_state == ST_IDLE && req) begin
         r_cycle_cnt <= '0;
      end else if (r_state == ST_RUN && !r_core_reset && r_cycle_cnt != 32'hFFFF_FFFF) begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
`endif

   assign in_ready   = r_in_ready;
   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign core_reset = r_core_reset;
   assign done       = r_done;
   assign overflow   = r_overflow;

endmodule

// File: doc/instr_loader.md
# instr_loader

Program-load and run sequencer that sits directly upstream of the core top level. It accepts 9-bit machine-code words from a host over a valid/ready stream and writes them into the instruction memory write port. It holds the core in reset while loading, then releases it and waits for the core's `done`. It reports completion to the host with a four-phase `req`/`done` handshake.

## Interface
- `D`, 12: instruction address width; matches core PC width.
- `W`, 9: machine-code word width.
- `DEPTH`, 128: maximum program length in words; must be ≤ 2**D.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  host request; level held high for the whole load+run transaction.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  W  machine-code word.
- `in_last`  in  1  marks final word of the program.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  D  instruction memory write address.
- `imem_wdata`  out  W  instruction memory write data.
- `core_reset`  out  1  active-high reset to core (drives core `reset`).
- `core_done`  in  1  core's `done` output.
- `done`  out  1  transaction complete, to host.
- `overflow`  out  1  program truncated at DEPTH words.
- `cycle_cnt`  out  32  core run cycles (only with `INSTR_LOADER_CYCLE_CNT_EN`).

## Operation
- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `done`=0, `overflow`=0, `cycle_cnt`=0.
- All outputs are registered.
- IDLE: `req`=1 → LOAD. Word counter cleared to 0, `overflow` cleared, `cycle_cnt` cleared.
- LOAD: `in_ready`=1. A beat is accepted when `in_valid && in_ready`. On acceptance, the next edge drives `imem_we`=1, `imem_addr`=counter, `imem_wdata`=`in_data`, and increments the counter.
- LOAD, last beat: accepting a beat with `in_last`=1, or the beat at counter DEPTH-1, goes to FLUSH and drops `in_ready`.
- LOAD, truncation: if the DEPTH-1 beat has `in_last`=0, `overflow`←1. Later host words are not accepted.
- FLUSH: one cycle. `imem_we`←0. `core_reset`←0 at the next edge. → RUN.
- RUN: `core_reset`=0. `core_done`=1 → DONE, with `core_reset`←1 and `done`←1 at the same edge.
- DONE: `done` held while `req`=1. `req`=0 → IDLE with `done`←0 at the next edge.
- Abort: `req`=0 in LOAD, FLUSH or RUN → IDLE at the next edge. `core_reset`←1, `imem_we`←0, `done` stays 0. Memory contents are left as written.
- Counter width is D bits. It never wraps, because it is capped at DEPTH-1.
- `imem_we` is never high in two consecutive cycles unless beats were accepted back-to-back. Full throughput is 1 word/cycle.

## Timing
- Beat accepted at edge t → memory write visible at edge t+1.
- Last beat at edge t → write at edge t+1 (FLUSH), `core_reset`=0 from edge t+2. The core's first fetch sees all words.
- `core_done` sampled at edge u → `done`=1 and `core_reset`=1 after edge u.
- `in_ready` falls the edge after the last beat is accepted. It rises the edge after entering LOAD, so it is never high in IDLE.
- `core_done` is ignored outside RUN.
- Asynchronous reset mid-transaction forces the reset values immediately, including `core_reset`=1.

## Configuration
- `INSTR_LOADER_CYCLE_CNT_EN` defined: `cycle_cnt` port exists. It counts every cycle in RUN with `core_reset`=0, saturates at 32'hFFFF_FFFF, is cleared on IDLE→LOAD, and holds its value through DONE/IDLE.
- Not defined: port and counter logic are absent; no other behaviour changes.

## Structure
- Package `instr_loader_pkg`: state enum (IDLE, LOAD, FLUSH, RUN, DONE), `INSTR_W`=9, `PROG_DEPTH`=128.
- Single module with no sub-module. The word counter and the optional cycle counter are inline.

## Test plan
- Normal load: 3 words 9'h1A3, 9'h045, 9'h1FF back-to-back, last on word 3 → writes to addr 0,1,2 on consecutive cycles. `core_reset` falls 2 cycles after the 3rd accept. `core_done` pulse → `done`=1. `req`=0 → `done`=0 next cycle.
- Backpressure gaps: `in_valid` toggled 1,0,1,0 → exactly 2 writes, no duplicate addresses, counter ends at 2.
- Overflow: 130 words with `in_last` never set → 128 writes (addr 0..127), `overflow`=1, `in_ready` low after the 128th word, core released.
- Abort: `req` dropped while in RUN → `core_reset`=1 next edge, `done` stays 0, state IDLE; a new `req` reloads from addr 0.
- Async reset asserted mid-LOAD → all outputs at reset values without a clock edge. After release, IDLE with `in_ready`=0.
- Cycle counter (macro on): `core_done` after 50 run cycles → `cycle_cnt`=50, held until the next `req`.
